// File: rtl/canvas_mem_writer_pkg.sv
// Canvas framebuffer geometry, colour codes and writer state encoding.
// Shared by the canvas writer and the VGA pixel readers.
package canvas_mem_writer_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int BRUSH_R  = 2;

  localparam logic [1:0] BG     = 2'd0;
  localparam logic [1:0] INK    = 2'd1;
  localparam logic [1:0] ACCENT = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PAINT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage

// File: rtl/canvas_mem_writer_if.sv
// Canvas BRAM port A write bundle.
// The writer owns it as master; the BRAM wrapper samples it as slave.
interface canvas_mem_writer_if;
  logic        wea;
  logic [16:0] addra;
  logic [1:0]  dina;

  modport master (
    output wea,
    output addra,
    output dina
  );

  modport slave (
    input wea,
    input addra,
    input dina
  );
endinterface

// File: rtl/canvas_addr_calc.sv
// Canvas pixel (x,y) to linear framebuffer address, x + 320*y.
// Pure shift-add so the readers can share it without a multiplier.
module canvas_addr_calc (
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  output logic [16:0] addr
);

  logic [16:0] y_ext;

  assign y_ext = {9'd0, y};
  assign addr  = {8'd0, x}
               + (y_ext << 8)
               + (y_ext << 6);

endmodule

// File: rtl/canvas_mem_writer.sv
// Canvas write port: turns mouse strokes into square brush writes
// and sweeps the whole framebuffer on a clear request.
module canvas_mem_writer
  import canvas_mem_writer_pkg::*;
#(
  parameter int         BRUSH_HW = BRUSH_R,
  parameter logic [1:0] INK_VAL  = INK,
  parameter logic [1:0] BG_VAL   = BG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 mouse_x,
  input  logic [9:0]                 mouse_y,
  input  logic                       MOUSE_LEFT,
  input  logic                       mouse_in_canvas,
  input  logic                       clear_req,
  canvas_mem_writer_if.master        bram,
  output logic                       busy,
  output logic                       clear_done
);

  localparam logic signed [10:0] R_POS = 11'(BRUSH_HW);
  localparam logic signed [10:0] R_NEG = -R_POS;
  localparam logic signed [10:0] H_LIM = 11'(H_RES);
  localparam logic signed [10:0] V_LIM = 11'(V_RES);
  localparam logic [16:0]        FB_END = 17'(FB_DEPTH);

  logic [1:0]        state;
  logic [8:0]        cx, cy;
  logic [8:0]        last_x, last_y;
  logic              last_valid;
  logic              clear_pend;
  logic signed [10:0] dx, dy;
  logic [16:0]       clr_addr;

  logic [8:0]        mx, my;
  logic              stroke_go;
  logic              clear_go;
  logic              first;
  logic [8:0]        bx, by;
  logic signed [10:0] ox, oy;
  logic signed [10:0] px, py;
  logic signed [10:0] nx, ny;
  logic              in_rng;
  logic              paint_done;
  logic [16:0]       pix_addr;
  logic              unused_lsb;

  assign mx = mouse_x[9:1];
  assign my = mouse_y[9:1];
  assign unused_lsb = ^{mouse_x[0], mouse_y[0]};

  assign clear_go  = clear_req || clear_pend;
  assign stroke_go = MOUSE_LEFT && mouse_in_canvas &&
                     (!last_valid ||
                      {mx, my} != {last_x, last_y});

  // The accepting IDLE cycle already issues the first brush pixel,
  // so the pixel source switches between live mouse and latched centre.
  assign first = (state == ST_IDLE);
  assign bx = first ? mx : cx;
  assign by = first ? my : cy;
  assign ox = first ? R_NEG : dx;
  assign oy = first ? R_NEG : dy;

  assign px = $signed({2'b00, bx}) + ox;
  assign py = $signed({2'b00, by}) + oy;

  assign in_rng = !px[10] && (px < H_LIM) &&
                  !py[10] && (py < V_LIM);

  always_comb begin
    nx = ox + 11'sd1;
    ny = oy;
    if (ox == R_POS) begin
      nx = R_NEG;
      ny = oy + 11'sd1;
    end
  end

  assign paint_done = (dy > R_POS);

  canvas_addr_calc u_addr (
    .x    (px[8:0]),
    .y    (py[7:0]),
    .addr (pix_addr)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bram.wea   <= 1'b0;
      bram.addra <= '0;
      bram.dina  <= '0;
      clear_done <= 1'b0;
      last_valid <= 1'b0;
      clear_pend <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      last_x     <= '0;
      last_y     <= '0;
      dx         <= '0;
      dy         <= '0;
      clr_addr   <= '0;
    end else begin
      clear_done <= 1'b0;
      bram.wea   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clear_go) begin
            state      <= ST_CLEAR;
            clear_pend <= 1'b0;
            bram.wea   <= 1'b1;
            bram.addra <= '0;
            bram.dina  <= BG_VAL;
            clr_addr   <= 17'd1;
          end else if (stroke_go) begin
            state      <= ST_PAINT;
            cx         <= mx;
            cy         <= my;
            last_x     <= mx;
            last_y     <= my;
            last_valid <= 1'b1;
            bram.wea   <= in_rng;
            bram.dina  <= INK_VAL;
            if (in_rng)
              bram.addra <= pix_addr;
            dx         <= nx;
            dy         <= ny;
          end else if (!MOUSE_LEFT) begin
            last_valid <= 1'b0;
          end
        end
        ST_PAINT: begin
          if (clear_req)
            clear_pend <= 1'b1;
          if (paint_done) begin
            state <= ST_IDLE;
          end else begin
            bram.wea  <= in_rng;
            bram.dina <= INK_VAL;
            if (in_rng)
              bram.addra <= pix_addr;
            dx <= nx;
            dy <= ny;
          end
        end
        ST_CLEAR: begin
          if (clr_addr == FB_END) begin
            state      <= ST_IDLE;
            clear_done <= 1'b1;
          end else begin
            bram.wea   <= 1'b1;
            bram.addra <= clr_addr;
            bram.dina  <= BG_VAL;
            clr_addr   <= clr_addr + 17'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_mem_writer.sv
// Bench for canvas_mem_writer: job-level model compared every cycle
// plus directed stroke/clear/reset scenarios with literal expectations.
module tb_canvas_mem_writer;
  import canvas_mem_writer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] mouse_x = '0;
  logic [9:0] mouse_y = '0;
  logic       left = 1'b0;
  logic       inc = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic       clear_done;

  canvas_mem_writer_if bram ();

  canvas_mem_writer dut (
    .clk             (clk),
    .rst             (rst),
    .mouse_x         (mouse_x),
    .mouse_y         (mouse_y),
    .MOUSE_LEFT      (left),
    .mouse_in_canvas (inc),
    .clear_req       (clear_req),
    .bram            (bram),
    .busy            (busy),
    .clear_done      (clear_done)
  );

  always #5 clk = ~clk;

  localparam int W  = 2 * BRUSH_R + 1;
  localparam int NB = W * W;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef enum int {J_NONE, J_PAINT, J_CLEAR} job_e;
  job_e job = J_NONE;
  int   idx = 0;
  int   mcx = 0;
  int   mcy = 0;
  bit   lv = 0;
  bit   pend = 0;
  bit   exp_cd = 0;
  bit   addr_zero = 0;
  bit   armed = 0;

  // Job-level model: a stroke is NB brush pixels, a clear is FB_DEPTH writes.
  always @(posedge clk) begin
    if (rst) begin
      job = J_NONE;
      lv = 0;
      pend = 0;
      exp_cd = 0;
      addr_zero = 1;
      armed = 1;
    end else begin
      exp_cd = 0;
      if (job == J_NONE) begin
        if (clear_req || pend) begin
          job = J_CLEAR;
          idx = 0;
          pend = 0;
          addr_zero = 0;
        end else if (left && inc &&
                     (!lv || int'(mouse_x) / 2 != mcx ||
                      int'(mouse_y) / 2 != mcy)) begin
          mcx = int'(mouse_x) / 2;
          mcy = int'(mouse_y) / 2;
          lv = 1;
          job = J_PAINT;
          idx = 0;
          addr_zero = 0;
        end else if (!left) begin
          lv = 0;
        end
      end else begin
        if (clear_req && job == J_PAINT)
          pend = 1;
        idx++;
        if (job == J_PAINT && idx == NB) begin
          job = J_NONE;
        end else if (job == J_CLEAR && idx == FB_DEPTH) begin
          job = J_NONE;
          exp_cd = 1;
        end
      end
    end
  end

  int n_wr = 0;
  int n_ink = 0;
  int n_bg = 0;
  int n_busy = 0;
  int n_cd = 0;
  int over = 0;
  bit seen [int];

  always @(posedge clk) begin
    int ex, ey, ea, ed;
    bit ew, eb;
    #2;
    if (armed) begin
      ew = 0;
      eb = 0;
      ea = 0;
      ed = 0;
      if (job == J_PAINT) begin
        ex = mcx + idx % W - BRUSH_R;
        ey = mcy + idx / W - BRUSH_R;
        ew = (ex >= 0 && ex < H_RES && ey >= 0 && ey < V_RES);
        ea = ey * H_RES + ex;
        ed = 1;
        eb = 1;
      end else if (job == J_CLEAR) begin
        ew = 1;
        ea = idx;
        ed = 0;
        eb = 1;
      end
      chk("wea", int'(bram.wea), int'(ew));
      chk("busy", int'(busy), int'(eb));
      chk("clear_done", int'(clear_done), int'(exp_cd));
      if (ew) begin
        chk("addra", int'(bram.addra), ea);
        chk("dina", int'(bram.dina), ed);
      end else if (addr_zero) begin
        chk("addra_rst", int'(bram.addra), 0);
      end
      if (bram.wea) begin
        n_wr++;
        if (bram.dina == INK) n_ink++;
        else n_bg++;
        seen[int'(bram.addra)] = 1;
        if (int'(bram.addra) >= FB_DEPTH) over++;
      end
      if (busy) n_busy++;
      if (clear_done) n_cd++;
    end
  end

  task automatic clr_cnt();
    n_wr = 0;
    n_ink = 0;
    n_bg = 0;
    n_busy = 0;
    n_cd = 0;
    over = 0;
    seen.delete();
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int x, int y);
    mouse_x = 10'(x);
    mouse_y = 10'(y);
    left = 1'b1;
    inc = 1'b1;
  endtask

  int corner00 [9] = '{0, 1, 2, 320, 321, 322, 640, 641, 642};

  initial begin
    int t;
    cyc(3);
    rst = 1'b0;
    cyc(10);
    chk("rst_wea", int'(bram.wea), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addra", int'(bram.addra), 0);
    chk("rst_cd", int'(clear_done), 0);

    clr_cnt();
    press(200, 100);
    cyc(40);
    chk("s1_writes", n_wr, 25);
    chk("s1_busy", n_busy, 25);
    chk("s1_centre", int'(seen.exists(16100)), 1);
    chk("s1_c_lo", int'(seen.exists(15458)), 1);
    chk("s1_c_hi", int'(seen.exists(16742)), 1);
    chk("s1_c_lohi", int'(seen.exists(98 + 320 * 52)), 1);
    mouse_x = 10'd201;
    mouse_y = 10'd101;
    cyc(30);
    chk("s1_same_px", n_wr, 25);
    mouse_x = 10'd204;
    cyc(30);
    chk("s1_moved", n_wr, 50);
    chk("s1_ink", n_ink, 50);
    left = 1'b0;
    cyc(3);

    clr_cnt();
    press(0, 0);
    cyc(35);
    left = 1'b0;
    chk("s2_writes", n_wr, 9);
    chk("s2_busy", n_busy, 25);
    foreach (corner00[i])
      chk($sformatf("s2_addr%0d", corner00[i]),
          int'(seen.exists(corner00[i])), 1);
    cyc(3);

    clr_cnt();
    press(639, 479);
    cyc(35);
    left = 1'b0;
    chk("s3_writes", n_wr, 9);
    chk("s3_last", int'(seen.exists(76799)), 1);
    chk("s3_over", over, 0);
    cyc(3);

    clr_cnt();
    press(100, 100);
    cyc(5);
    clear_req = 1'b1;
    cyc(1);
    clear_req = 1'b0;
    left = 1'b0;
    cyc(100);
    clear_req = 1'b1;
    cyc(1);
    clear_req = 1'b0;
    t = 0;
    while (n_cd == 0 && t < 80000) begin
      cyc(1);
      t++;
    end
    chk("s4_clear_in_time", int'(t < 80000), 1);
    cyc(5);
    chk("s4_ink", n_ink, 25);
    chk("s4_bg", n_bg, FB_DEPTH);
    chk("s4_cd", n_cd, 1);
    chk("s4_over", over, 0);
    chk("s4_idle", int'(busy), 0);

    clr_cnt();
    clear_req = 1'b1;
    cyc(1);
    clear_req = 1'b0;
    t = 0;
    while (!(bram.wea && bram.addra == 17'd1000) && t < 2000) begin
      cyc(1);
      t++;
    end
    chk("s5_reach_1000", int'(t < 2000), 1);
    rst = 1'b1;
    cyc(1);
    chk("s5_rst_wea", int'(bram.wea), 0);
    chk("s5_rst_busy", int'(busy), 0);
    rst = 1'b0;
    cyc(2);
    chk("s5_no_cd", n_cd, 0);
    clr_cnt();
    press(50, 60);
    cyc(35);
    left = 1'b0;
    chk("s5_writes", n_wr, 25);
    chk("s5_centre", int'(seen.exists(25 + 320 * 30)), 1);
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
